// File: rtl/vga_game_pkg.sv
// Shared turn codes and sequencer states for the game datapath and the turn register.
package vga_game_pkg;

    typedef enum logic [1:0] {
        TURN_NONE = 2'b00,
        TURN_P1   = 2'b01,
        TURN_P2   = 2'b10
    } turn_code_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_P1,
        ST_P2,
        ST_DONE
    } turn_state_t;

    function automatic turn_code_t state_code(input turn_state_t s);
        case (s)
            ST_P1:   return TURN_P1;
            ST_P2:   return TURN_P2;
            default: return TURN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/turn_sequencer_timer.sv
// Per-turn hold timer: counts cycles while enabled, pulses expire on the last allowed cycle.
module turn_timer
    import vga_game_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd250_000_000,
    parameter int          TIMEOUT_W      = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 32'd1);

    logic [TIMEOUT_W-1:0] count_q;
    logic [TIMEOUT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Firing always causes a turn change, which clears the count, so it never wraps.
    assign expire = enable && (count_q == LAST);

endmodule

// File: rtl/turn_sequencer.sv
// Game-turn controller driving the turn register's write port.
// Optional forced-pass timer is built only when TURN_TIMEOUT_EN is defined.
module turn_sequencer
    import vga_game_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd250_000_000,
    parameter int          TIMEOUT_W      = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       move_valid,
    input  logic       game_over,
    output logic       write,
    output logic [1:0] wr_data,
    output logic       turn_p1,
    output logic       turn_p2,
    output logic       move_ack,
    output logic       timeout
);

    turn_state_t state_q, state_d;
    turn_code_t  wr_data_q, wr_data_d;
    logic        write_q, write_d;
    logic        turn_p1_q, turn_p1_d;
    logic        turn_p2_q, turn_p2_d;
    logic        move_ack_q, move_ack_d;
    logic        timeout_q, timeout_d;
    logic        in_turn;
    logic        expire;

    assign in_turn = (state_q == ST_P1) || (state_q == ST_P2);

`ifdef TURN_TIMEOUT_EN
    turn_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TIMEOUT_W     (TIMEOUT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (write_d),
        .enable(in_turn),
        .expire(expire)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, 32'(TIMEOUT_W), in_turn};
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        move_ack_d = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            ST_P1, ST_P2: begin
                if (start) begin
                    state_d = ST_P1;
                end else if (game_over) begin
                    state_d = ST_DONE;
                end else if (move_valid) begin
                    state_d    = (state_q == ST_P1) ? ST_P2 : ST_P1;
                    move_ack_d = 1'b1;
                end else if (expire) begin
                    state_d   = (state_q == ST_P1) ? ST_P2 : ST_P1;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    state_d = ST_P1;
                end
            end
        endcase
        // A restart from P1 stays in P1 but still counts as a transition.
        write_d   = start || (state_d != state_q);
        wr_data_d = state_code(state_d);
        turn_p1_d = (state_d == ST_P1);
        turn_p2_d = (state_d == ST_P2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_data_q  <= TURN_NONE;
            write_q    <= 1'b0;
            turn_p1_q  <= 1'b0;
            turn_p2_q  <= 1'b0;
            move_ack_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_data_q  <= wr_data_d;
            write_q    <= write_d;
            turn_p1_q  <= turn_p1_d;
            turn_p2_q  <= turn_p2_d;
            move_ack_q <= move_ack_d;
            timeout_q  <= timeout_d;
        end
    end

    assign write    = write_q;
    assign wr_data  = wr_data_q;
    assign turn_p1  = turn_p1_q;
    assign turn_p2  = turn_p2_q;
    assign move_ack = move_ack_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: directed scenarios then random traffic against a turn model.
// Forced-pass expectations follow TURN_TIMEOUT_EN, matching the design build.
module tb_turn_sequencer;

    localparam int TB_TIMEOUT = 8;
`ifdef TURN_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       move_valid;
    logic       game_over;
    logic       write;
    logic [1:0] wr_data;
    logic       turn_p1;
    logic       turn_p2;
    logic       move_ack;
    logic       timeout;

    int vectors   = 0;
    int failures  = 0;
    int cycle_num = 0;

    // Reference model: which player holds the turn (0 none, 1 or 2) and how long they have held it.
    int m_turn = 0;
    int m_held = 0;
    bit exp_write, exp_ack, exp_to;

    always #5 clk = ~clk;

    turn_sequencer #(
        .TIMEOUT_CYCLES(32'(TB_TIMEOUT)),
        .TIMEOUT_W     (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .move_valid(move_valid),
        .game_over (game_over),
        .write     (write),
        .wr_data   (wr_data),
        .turn_p1   (turn_p1),
        .turn_p2   (turn_p2),
        .move_ack  (move_ack),
        .timeout   (timeout)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cycle_num, observed, expected);
        end
    endtask

    task automatic modelStep(input bit s, input bit mv, input bit go, input bit rst);
        exp_write = 1'b0;
        exp_ack   = 1'b0;
        exp_to    = 1'b0;
        if (rst) begin
            m_turn = 0;
            m_held = 0;
        end else if (s) begin
            m_turn    = 1;
            m_held    = 0;
            exp_write = 1'b1;
        end else if (m_turn != 0) begin
            if (go) begin
                m_turn    = 0;
                exp_write = 1'b1;
            end else if (mv) begin
                m_turn    = 3 - m_turn;
                m_held    = 0;
                exp_write = 1'b1;
                exp_ack   = 1'b1;
            end else if (TIMEOUT_ON && m_held == TB_TIMEOUT - 1) begin
                m_turn    = 3 - m_turn;
                m_held    = 0;
                exp_write = 1'b1;
                exp_to    = 1'b1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic applyStimulus(input bit s, input bit mv, input bit go, input bit rst);
        start      = s;
        move_valid = mv;
        game_over  = go;
        reset      = rst;
        @(posedge clk);
        modelStep(s, mv, go, rst);
        #1;
        cycle_num++;
        checkOutput("write",    32'(write),    32'(exp_write));
        checkOutput("wr_data",  32'(wr_data),  32'(m_turn));
        checkOutput("turn_p1",  32'(turn_p1),  32'(m_turn == 1));
        checkOutput("turn_p2",  32'(turn_p2),  32'(m_turn == 2));
        checkOutput("move_ack", 32'(move_ack), 32'(exp_ack));
        checkOutput("timeout",  32'(timeout),  32'(exp_to));
    endtask

    initial begin
        start      = 1'b0;
        move_valid = 1'b0;
        game_over  = 1'b0;
        reset      = 1'b1;

        // Reset, idle, then start: P1 written once.
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 1, 1, 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);

        // Three back-to-back moves, then game_over and move together in P2.
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);

        // Restart from DONE, move to P2, reset mid-turn, start again.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);

        // Restart while in P1, then game_over held across a restart.
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0);

        // Long idle hold in P1: forced passes only when the timer is built.
        for (int i = 0; i < 100; i++) applyStimulus(0, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus($urandom_range(99) < 5,
                          $urandom_range(99) < 25,
                          $urandom_range(99) < 6,
                          $urandom_range(99) < 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
        $finish;
    end

endmodule

// File: doc/turn_sequencer.md
# turn_sequencer

Game-turn controller that drives the write side of the two-bit turn register. It starts a game, alternates turns between player 1 and player 2 on each completed move, and clears the turn when the game ends. Each change is issued as a single-cycle `write` strobe with `wr_data`, which connect directly to the register's `write`/`wrData` inputs. The block sits between the board/move-detection logic and that register, which feeds the VGA player indicators.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 32'd250_000_000 — cycles a player may hold the turn before a forced pass; used only with `TURN_TIMEOUT_EN`.
- `TIMEOUT_W`, default 32 — width of the turn timer.

Ports:
- `clk` in 1 — single system clock; all logic on its rising edge.
- `reset` in 1 — synchronous, active-high.
- `start` in 1 — one-cycle pulse: begin/restart a game, player 1 first.
- `move_valid` in 1 — one-cycle pulse: current player completed a move.
- `game_over` in 1 — level: win or draw detected by board logic.
- `write` out 1 — one-cycle strobe to the turn register.
- `wr_data` out 2 — turn code: 2'b00 none, 2'b01 player 1, 2'b10 player 2; 2'b11 never driven.
- `turn_p1` out 1 — registered, high while in P1.
- `turn_p2` out 1 — registered, high while in P2.
- `move_ack` out 1 — one-cycle pulse when a `move_valid` causes a turn change.
- `timeout` out 1 — one-cycle pulse on a forced pass (0 without the macro).

## Operation
- States: IDLE, P1, P2, DONE. `wr_data` always equals the current state's code: IDLE and DONE 00, P1 01, P2 10.
- Reset state is IDLE. Reset values: `write`, `move_ack`, `timeout`, `turn_p1`, `turn_p2` = 0; `wr_data` = 00.
- No write is issued on reset, because the register clears itself on the same reset.
- IDLE:
  - `start` → P1, write 01.
  - `move_valid` and `game_over` are ignored.
- P1 (and P2 symmetrically), with priority `start` > `game_over` > `move_valid` > timeout:
  - `start` → P1, write 01. This applies even if already in P1; the timer clears.
  - `game_over` → DONE, write 00.
  - `move_valid` → other player, write the new code, `move_ack` pulse.
  - timeout → other player, write the new code, `timeout` pulse, no `move_ack`.
- DONE:
  - `start` → P1, write 01.
  - All other inputs are ignored.
- Exactly one write is issued per state transition, and no write occurs without a transition (the restart case counts as a transition).
- `game_over` that is still high after a restart takes effect on the next cycle in P1 (P1 → DONE).

## Timing
- All outputs are registered. An input sampled at edge N produces `write`/`wr_data`/`turn_*`/`move_ack` at edge N+1, i.e. one cycle of latency.
- `write` is high for exactly one cycle, and `wr_data` holds the new code in that same cycle and afterwards.
- Back-to-back `move_valid` on consecutive cycles gives two turn changes and two write strobes on consecutive cycles.
- `reset` overrides everything. Asserting it mid-turn returns the block to IDLE in the next cycle and suppresses any pending strobe.
- Turn timer:
  - Clears on every entry to P1/P2.
  - Increments each cycle while in P1/P2.
  - Fires when its count equals `TIMEOUT_CYCLES-1`.
  - The timer is `TIMEOUT_W` bits wide and never wraps, because it always clears on firing.

## Configuration
- `TURN_TIMEOUT_EN` defined: the turn timer is instantiated, forced passes occur, and `timeout` pulses.
- `TURN_TIMEOUT_EN` undefined: no counter logic is built, `timeout` is tied to 0, and a turn lasts indefinitely until `move_valid`/`game_over`/`start`.

## Structure
- Shared package `vga_game_pkg` contains:
  - `turn_code_t` (TURN_NONE = 2'b00, TURN_P1 = 2'b01, TURN_P2 = 2'b10);
  - state enum `turn_state_t`.
- The turn register is updated to use the same package constants.
- Sub-module `turn_timer` (inputs: clear, enable; output: expire pulse) is instantiated only under `TURN_TIMEOUT_EN`.

## Test plan
- Reset, then `start` at cycle 5 → `write` = 1 at cycle 6 with `wr_data` = 01, `turn_p1` = 1; `write` = 0 at cycle 7.
- `move_valid` ×3 on consecutive cycles from P1 → `wr_data` sequence 10, 01, 10 with three consecutive write strobes and three `move_ack` pulses.
- In P2, assert `game_over` and `move_valid` together → DONE, a single write with 00, no `move_ack`. A following `move_valid` produces no write.
- `reset` asserted mid-P2 → next cycle all outputs 0 and `wr_data` = 00, no write strobe. A later `start` writes 01.
- `start` while in P1 → write 01, timer cleared. `start` in DONE → write 01.
- With `TURN_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8: enter P1 with no moves → after 8 cycles one `timeout` pulse and a write with 10. Without the macro, 100 idle cycles in P1 → no write, `timeout` stays 0.
